// File: rtl/feed_pkg.sv
// Shared feed definitions for the ITCH framer and the order-book parser:
// frame geometry, field bit positions, message codes and a byte-packing helper.
package feed_pkg;

    localparam int MSG_BYTES  = 40;
    localparam int MIN_BYTES  = 34;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_W    = 8 * MSG_BYTES;

    localparam int REQ_TYPE_MSB = 319;
    localparam int ORDER_ID_MSB = 247;
    localparam int STOCK_ID_MSB = 183;
    localparam int SIDE_MSB     = 151;
    localparam int QTY_MSB      = 143;
    localparam int PRICE_MSB    = 111;

    localparam logic [7:0] REQ_TYPE_ADD      = 8'h53;
    localparam logic [7:0] REQ_TYPE_DELETE   = 8'h44;
    localparam logic [7:0] REQ_TYPE_DECREASE = 8'h45;

    localparam logic [31:0] STOCK1 = 32'h0000_0010;
    localparam logic [31:0] STOCK2 = 32'h0000_0020;
    localparam logic [31:0] STOCK3 = 32'h0000_0030;
    localparam logic [31:0] STOCK4 = 32'h0000_0040;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } framer_state_e;

    // Writes data into byte slot 'slot' (slot 0 is the MSB byte); slots past the frame are ignored.
    function automatic logic [FRAME_W-1:0] place_byte(input logic [FRAME_W-1:0] frame,
                                                      input logic [5:0]         slot,
                                                      input logic [7:0]         data);
        logic [FRAME_W-1:0] f;
        f = frame;
        for (int k = 0; k < MSG_BYTES; k++) begin
            if (slot == 6'(k)) begin
                f[FRAME_W-1-8*k -: 8] = data;
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/itch_msg_framer_frame_fifo.sv
// DEPTH x WIDTH synchronous frame FIFO whose head entry is held in a register,
// so a frame pushed into an empty queue is visible on the same edge.
module frame_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 320
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] head_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_next_s;
    logic [AW:0]      count_r;
    logic             pop_en_s;
    logic             push_en_s;

    assign pop_en_s  = pop && (count_r != '0);
    assign push_en_s = push && ((count_r != CNT_FULL) || pop_en_s);
    assign rd_next_s = rd_ptr_r + PTR_ONE;

    assign head  = head_r;
    assign count = count_r;
    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == '0);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the registered head frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_next_s;
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            // With two or more entries the successor is already in the array; otherwise it is the incoming frame.
            if (pop_en_s) begin
                if (count_r > CNT_ONE) begin
                    head_r <= mem_r[rd_next_s];
                end else if (push_en_s) begin
                    head_r <= push_data;
                end else begin
                    head_r <= '0;
                end
            end else if (push_en_s && (count_r == '0)) begin
                head_r <= push_data;
            end
        end
    end

endmodule

// File: rtl/itch_msg_framer.sv
// Packs the feed byte stream into fixed 40-byte frames (MSB-first), drops runts,
// truncates oversize messages, and queues complete frames for the parser.
module itch_msg_framer
    import feed_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    input  logic               buf_pop,
    output logic [FRAME_W-1:0] ff_buffer,
    output logic               buffer_not_empty,
    output logic               err_overflow,
    output logic               err_runt
);

    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam logic [5:0] CNT_SAT = 6'(MSG_BYTES + 1);

    framer_state_e      state_r;
    framer_state_e      state_nxt_s;
    logic [5:0]         byte_cnt_r;
    logic [5:0]         cnt_nxt_s;
    logic [FRAME_W-1:0] asm_r;
    logic [FRAME_W-1:0] asm_nxt_s;
    logic [FRAME_W-1:0] frame_s;
    logic [FRAME_W-1:0] push_data_s;
    logic [6:0]         msg_len_s;
    logic               push_s;
    logic               push_ok_s;
    logic               in_ready_r;
    logic               ovf_r;
    logic               runt_r;
    logic               ovf_nxt_s;
    logic               runt_nxt_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;

    // A full queue can still take a frame when the parser frees the head on the same edge.
    assign push_ok_s = !fifo_full_s || (buf_pop && !fifo_empty_s);
    assign frame_s   = place_byte(asm_r, byte_cnt_r, in_data);
    assign msg_len_s = {1'b0, byte_cnt_r} + 7'd1;

    assign in_ready         = in_ready_r;
    assign buffer_not_empty = (fifo_count_s != '0);
    assign err_overflow     = ovf_r;
    assign err_runt         = runt_r;

    // Next-state, packing and push decisions for the framer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = byte_cnt_r;
        asm_nxt_s   = asm_r;
        push_s      = 1'b0;
        push_data_s = asm_r;
        ovf_nxt_s   = 1'b0;
        runt_nxt_s  = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (in_valid && in_ready_r) begin
                    if (in_last) begin
                        cnt_nxt_s = 6'd0;
                        if (msg_len_s < 7'(MIN_BYTES)) begin
                            runt_nxt_s = 1'b1;
                            asm_nxt_s  = '0;
                        end else begin
                            ovf_nxt_s = (msg_len_s > 7'(MSG_BYTES));
                            if (push_ok_s) begin
                                push_s      = 1'b1;
                                push_data_s = frame_s;
                                asm_nxt_s   = '0;
                            end else begin
                                asm_nxt_s   = frame_s;
                                state_nxt_s = ST_HOLD;
                            end
                        end
                    end else begin
                        asm_nxt_s = frame_s;
                        cnt_nxt_s = (byte_cnt_r == CNT_SAT) ? CNT_SAT : byte_cnt_r + 6'd1;
                    end
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (push_ok_s) begin
                    push_s      = 1'b1;
                    push_data_s = asm_r;
                    asm_nxt_s   = '0;
                    cnt_nxt_s   = 6'd0;
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_COLLECT;
                cnt_nxt_s   = 6'd0;
                asm_nxt_s   = '0;
            end
        endcase
    end

    // Framer state, assembly register and registered handshake/error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_COLLECT;
            byte_cnt_r <= 6'd0;
            asm_r      <= '0;
            in_ready_r <= 1'b0;
            ovf_r      <= 1'b0;
            runt_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            byte_cnt_r <= cnt_nxt_s;
            asm_r      <= asm_nxt_s;
            in_ready_r <= (state_nxt_s == ST_COLLECT);
            ovf_r      <= ovf_nxt_s;
            runt_r     <= runt_nxt_s;
        end
    end

    frame_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_W)
    ) u_frame_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (buf_pop),
        .head      (ff_buffer),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

endmodule

// File: tb/tb_itch_msg_framer.sv
// Scoreboard bench for itch_msg_framer: the stimulus queues expected frames,
// a monitor compares the head frame on every effective buf_pop.
module tb_itch_msg_framer;
    import feed_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         buf_pop;
    logic [319:0] ff_buffer;
    logic         buffer_not_empty;
    logic         err_overflow;
    logic         err_runt;

    int           checks = 0;
    int           errors = 0;
    logic [319:0] exp_q [$];
    logic [7:0]   mb [64];
    logic [7:0]   rts [5];
    logic [319:0] frame_b;

    always #5 clk = ~clk;

    itch_msg_framer dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .buf_pop          (buf_pop),
        .ff_buffer        (ff_buffer),
        .buffer_not_empty (buffer_not_empty),
        .err_overflow     (err_overflow),
        .err_runt         (err_runt)
    );

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: first min(len,40) bytes MSB-first, remaining slots zero.
    function automatic logic [319:0] model(input int len);
        logic [319:0] f;
        f = '0;
        for (int k = 0; k < len && k < 40; k++) begin
            f[319-8*k -: 8] = mb[k];
        end
        return f;
    endfunction

    task automatic build(input logic [7:0] rt, input logic [31:0] stock,
                         input logic [31:0] qty, input logic [7:0] seed);
        for (int k = 0; k < 64; k++) begin
            mb[k] = seed + 8'(k);
        end
        mb[0]  = rt;
        mb[17] = stock[31:24]; mb[18] = stock[23:16]; mb[19] = stock[15:8]; mb[20] = stock[7:0];
        mb[22] = qty[31:24];   mb[23] = qty[23:16];   mb[24] = qty[15:8];   mb[25] = qty[7:0];
    endtask

    task automatic send_bytes(input int len, input bit with_last, input bit pop_last);
        int t;
        for (int k = 0; k < len; k++) begin
            in_valid = 1'b1;
            in_data  = mb[k];
            in_last  = with_last && (k == len - 1);
            if (pop_last && (k == len - 1)) buf_pop = 1'b1;
            t = 0;
            while (!in_ready && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 200) begin
                checks++; errors++;
                $display("FAIL in_ready_timeout: got in_ready 0 for 200 cycles, required 1");
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            buf_pop  = 1'b0;
        end
    endtask

    task automatic send_msg(input int len, input bit pop_last);
        if (len >= MIN_BYTES) exp_q.push_back(model(len));
        send_bytes(len, 1'b1, pop_last);
    endtask

    task automatic pop_one();
        buf_pop = 1'b1;
        @(posedge clk); #1;
        buf_pop = 1'b0;
    endtask

    // Monitor: every effective pop consumes the head, which must match the oldest expected frame.
    always @(negedge clk) begin
        if (!reset && buf_pop && buffer_not_empty) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard: got frame %0h, expected no frame", ff_buffer);
            end else begin
                chk("scoreboard", ff_buffer, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; buf_pop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_not_empty", buffer_not_empty, 1'b0);
        chk("reset_ff_buffer", ff_buffer, 320'd0);
        chk("reset_errs", {err_overflow, err_runt}, 2'b00);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("in_ready_after_reset", in_ready, 1'b1);

        // Full 40-byte frame, one-cycle latency and field placement
        build(8'h53, 32'h10, 32'd100, 8'h01);
        send_msg(40, 1'b0);
        chk("pack_not_empty", buffer_not_empty, 1'b1);
        chk("pack_req_type", ff_buffer[319:312], 8'h53);
        chk("pack_stock", ff_buffer[183:152], 32'h10);
        chk("pack_qty", ff_buffer[143:112], 32'd100);
        chk("pack_no_err", {err_overflow, err_runt}, 2'b00);
        pop_one();
        chk("pack_drained", buffer_not_empty, 1'b0);

        // Minimum-length message: padding reads as zero, no error
        build(REQ_TYPE_DELETE, STOCK2, 32'd7, 8'h20);
        send_msg(34, 1'b0);
        chk("min_no_runt", err_runt, 1'b0);
        chk("min_padding_zero", ff_buffer[47:0], 48'd0);
        chk("min_price", ff_buffer[111:48], 64'h3a3b_3c3d_3e3f_4041);
        pop_one();

        // Runt message dropped
        build(REQ_TYPE_ADD, STOCK1, 32'd1, 8'h40);
        send_msg(20, 1'b0);
        chk("runt_pulse", err_runt, 1'b1);
        chk("runt_dropped", buffer_not_empty, 1'b0);
        @(posedge clk); #1;
        chk("runt_pulse_end", err_runt, 1'b0);

        // Oversize message truncated, next message starts at slot 0
        build(REQ_TYPE_DECREASE, STOCK3, 32'd9, 8'h60);
        send_msg(45, 1'b0);
        chk("ovf_pulse", err_overflow, 1'b1);
        chk("ovf_last_slot", ff_buffer[7:0], 8'h87);
        @(posedge clk); #1;
        chk("ovf_pulse_end", err_overflow, 1'b0);
        build(REQ_TYPE_ADD, STOCK4, 32'd3, 8'h90);
        send_msg(36, 1'b0);
        pop_one();
        pop_one();
        chk("ovf_drained", buffer_not_empty, 1'b0);

        // Backpressure: four frames fill the queue, fifth waits in HOLD
        rts[0] = 8'h53; rts[1] = 8'h44; rts[2] = 8'h45; rts[3] = 8'h53; rts[4] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            build(rts[i], STOCK1, 32'(i), 8'(i * 16 + 5));
            send_msg(40, 1'b0);
        end
        build(rts[4], STOCK2, 32'd4, 8'h77);
        send_msg(40, 1'b0);
        chk("hold_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_stays", in_ready, 1'b0);
        chk("hold_head", ff_buffer[319:312], rts[0]);
        pop_one();
        chk("hold_release", in_ready, 1'b1);
        for (int i = 1; i < 5; i++) begin
            chk("order_req_type", ff_buffer[319:312], rts[i]);
            pop_one();
        end
        chk("order_drained", buffer_not_empty, 1'b0);

        // Push and pop on the same edge with one frame queued
        build(REQ_TYPE_ADD, STOCK1, 32'd11, 8'hA0);
        send_msg(40, 1'b0);
        build(REQ_TYPE_DELETE, STOCK3, 32'd12, 8'hB0);
        frame_b = model(40);
        send_msg(40, 1'b1);
        chk("pushpop_not_empty", buffer_not_empty, 1'b1);
        chk("pushpop_head", ff_buffer, frame_b);
        pop_one();
        chk("pushpop_count_one", buffer_not_empty, 1'b0);

        // Pop of an empty queue is ignored
        pop_one();
        chk("empty_pop", buffer_not_empty, 1'b0);
        build(REQ_TYPE_DECREASE, STOCK4, 32'd13, 8'hC0);
        send_msg(40, 1'b0);
        chk("after_empty_pop_head", ff_buffer[319:312], 8'h45);
        pop_one();
        chk("after_empty_pop_drained", buffer_not_empty, 1'b0);

        // Reset mid-message with three frames queued
        for (int i = 0; i < 3; i++) begin
            build(rts[i], STOCK2, 32'(i), 8'(i * 8 + 1));
            send_msg(40, 1'b0);
        end
        build(8'hEE, STOCK1, 32'hFFFF_FFFF, 8'hF0);
        send_bytes(12, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_in_ready", in_ready, 1'b0);
        chk("midreset_not_empty", buffer_not_empty, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("postreset_ff_buffer", ff_buffer, 320'd0);
        chk("postreset_in_ready", in_ready, 1'b1);
        build(REQ_TYPE_ADD, STOCK3, 32'd21, 8'h10);
        send_msg(34, 1'b0);
        chk("postreset_req_type", ff_buffer[319:312], 8'h53);
        chk("postreset_padding", ff_buffer[47:0], 48'd0);
        pop_one();

        chk("scoreboard_empty", 320'(exp_q.size()), 320'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
